axis_cmd_fetcher: RTL and testbench

Memory-to-stream command fetcher: reads a contiguous command list from memory over an AXI4 read channel and emits it as the 32-bit AXI Stream command interface consumed by the renderer's `s_cmd_axis` port. It is the transmitting end of the command stream and sits between the shared AXI memory and the rasterizer. It splits the list into 4 KiB-safe bursts, flags the final beat with `tlast` and reports completion and read errors.

---
 rtl/axis_cmd_fetcher.sv | 162 ++++++++++++++++
 tb/tb_axis_cmd_fetcher.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_cmd_fetcher.sv
// axis_cmd_fetcher: AXI4 read master that fetches a contiguous command list and emits it as an AXI Stream.
// Define AXIS_CMD_FETCHER_SKID_BUFFER_EN to place a 2-entry skid buffer between R and the stream.
module axis_cmd_fetcher #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 25,
  parameter int ID_WIDTH      = 8,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [15:0]           length_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  m_cmd_axis_tvalid,
  input  logic                  m_cmd_axis_tready,
  output logic                  m_cmd_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_cmd_axis_tdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           remaining;     // beats still to leave on the stream
  logic [15:0]           rd_remaining;  // beats still to be accepted from R
  logic                  error_q;
  logic                  r_hs, s_hs;
  logic [12:0]           bound_beats;
  logic [16:0]           burst;
  logic                  unused_rid;

  assign unused_rid = ^m_axi_rid;

  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = '0;
  assign m_axi_araddr  = addr;
  assign m_axi_arvalid = (state == ADDR) && (rd_remaining != '0);

  assign busy  = (state == ADDR) || (state == DATA);
  assign done  = (state == DONE);
  assign error = error_q;

  always_comb begin
    bound_beats = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;
    burst = {1'b0, rd_remaining};
    if ({4'b0, bound_beats} < burst) burst = {4'b0, bound_beats};
    if (17'(MAX_BURST_LEN) < burst) burst = 17'(MAX_BURST_LEN);
    m_axi_arlen = m_axi_arvalid ? 8'(burst - 17'd1) : '0;
  end

  // An empty list spends one cycle in ADDR without arvalid, so done lands two cycles after start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = ADDR;
      ADDR: begin
        if (rd_remaining == '0)  state_next = DONE;
        else if (m_axi_arready)  state_next = DATA;
      end
      DATA: begin
        if (s_hs && remaining == 16'd1)                               state_next = DONE;
        else if (r_hs && m_axi_rlast && rd_remaining != 16'd1)        state_next = ADDR;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      rd_remaining <= '0;
      error_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        addr         <= start_addr & ALIGN_MASK;
        remaining    <= length_beats;
        rd_remaining <= length_beats;
        error_q      <= 1'b0;
      end else begin
        if (r_hs) begin
          addr         <= addr + ADDR_WIDTH'(BYTES);
          rd_remaining <= rd_remaining - 16'd1;
          if (m_axi_rresp != 2'b00) error_q <= 1'b1;
        end
        if (s_hs) remaining <= remaining - 16'd1;
      end
    end
  end

`ifdef AXIS_CMD_FETCHER_SKID_BUFFER_EN
  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  wr_ptr, rd_ptr, rready_q;
  logic [1:0]            count, count_next;

  assign m_axi_rready      = rready_q;
  assign r_hs              = m_axi_rvalid && rready_q;
  assign m_cmd_axis_tvalid = (count != 2'd0);
  assign m_cmd_axis_tdata  = skid_mem[rd_ptr];
  assign s_hs              = m_cmd_axis_tvalid && m_cmd_axis_tready;

  always_comb count_next = count + 2'(r_hs) - 2'(s_hs);

  // rready is a registered promise that a slot is free next cycle; at most one push per cycle keeps it safe.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      rready_q <= 1'b0;
    end else begin
      if (r_hs) wr_ptr <= ~wr_ptr;
      if (s_hs) rd_ptr <= ~rd_ptr;
      count    <= count_next;
      rready_q <= (state_next == DATA) && ((rd_remaining - 16'(r_hs)) != '0) && (count_next != 2'd2);
    end
  end

  always_ff @(posedge aclk) begin
    if (r_hs) skid_mem[wr_ptr] <= m_axi_rdata;
  end
`else
  assign m_axi_rready      = (state == DATA) && m_cmd_axis_tready;
  assign r_hs              = m_axi_rvalid && m_axi_rready;
  assign m_cmd_axis_tvalid = (state == DATA) && m_axi_rvalid;
  assign m_cmd_axis_tdata  = m_axi_rdata;
  assign s_hs              = m_cmd_axis_tvalid && m_cmd_axis_tready;
`endif

  assign m_cmd_axis_tlast = m_cmd_axis_tvalid && (remaining == 16'd1);

endmodule

// File: tb/tb_axis_cmd_fetcher.sv
// tb_axis_cmd_fetcher: directed bench for axis_cmd_fetcher with a behavioural AXI4 read slave and stream sink.
module tb_axis_cmd_fetcher;
  localparam int DW = 32;
  localparam int AW = 25;
  localparam int IW = 8;

  logic          aclk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [15:0]   length_beats = '0;
  logic          busy, done, error;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [IW-1:0] m_axi_rid = '0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rlast = 1'b0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic          m_cmd_axis_tvalid;
  logic          m_cmd_axis_tready = 1'b0;
  logic          m_cmd_axis_tlast;
  logic [DW-1:0] m_cmd_axis_tdata;

  always #5 aclk = ~aclk;

  axis_cmd_fetcher #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_BURST_LEN(16)
  ) dut (
    .aclk(aclk), .rst(rst), .start(start), .start_addr(start_addr), .length_beats(length_beats),
    .busy(busy), .done(done), .error(error),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_cmd_axis_tvalid(m_cmd_axis_tvalid),
    .m_cmd_axis_tready(m_cmd_axis_tready), .m_cmd_axis_tlast(m_cmd_axis_tlast),
    .m_cmd_axis_tdata(m_cmd_axis_tdata)
  );

  int total = 0;
  int bad = 0;

  logic          sl_active;
  logic [AW-1:0] sl_addr;
  int            sl_left, sl_rcount, err_beat, err_rise_at;
  bit            rand_tready = 1'b0;
  int            cyc, done_cnt, done_cyc, busy_cnt, last_s_cyc;
  logic [AW-1:0] ar_addr_q [$];
  logic [7:0]    ar_len_q [$];
  logic [DW-1:0] s_data [$];
  logic          s_last [$];

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic slave_clear();
    sl_active = 1'b0; sl_addr = '0; sl_left = 0; sl_rcount = 0; err_beat = -1; err_rise_at = -1;
    cyc = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0; last_s_cyc = 0;
    ar_addr_q.delete(); ar_len_q.delete(); s_data.delete(); s_last.delete();
  endtask

  // One clock: drive slave/sink at negedge, then log the handshakes that the next posedge will complete.
  task automatic step();
    @(negedge aclk);
    m_axi_arready     = 1'b1;
    m_axi_rvalid      = sl_active;
    m_axi_rdata       = sl_active ? word_at(sl_addr) : '0;
    m_axi_rlast       = sl_active && (sl_left == 1);
    m_axi_rresp       = (sl_active && sl_rcount == err_beat) ? 2'b10 : 2'b00;
    m_cmd_axis_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    cyc++;
    if (error === 1'b1 && err_rise_at < 0) err_rise_at = sl_rcount;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (busy === 1'b1) busy_cnt++;
    if (m_cmd_axis_tvalid && m_cmd_axis_tready) begin
      s_data.push_back(m_cmd_axis_tdata);
      s_last.push_back(m_cmd_axis_tlast);
      last_s_cyc = cyc;
    end
    if (m_axi_rvalid && m_axi_rready) begin
      sl_addr = sl_addr + 25'd4;
      sl_left--;
      sl_rcount++;
      if (sl_left == 0) sl_active = 1'b0;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      ar_addr_q.push_back(m_axi_araddr);
      ar_len_q.push_back(m_axi_arlen);
      sl_active = 1'b1;
      sl_addr   = m_axi_araddr;
      sl_left   = int'(m_axi_arlen) + 1;
    end
  endtask

  task automatic kick(input logic [AW-1:0] a, input logic [15:0] n);
    start_addr = a; length_beats = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("FAIL %s_timeout: done not seen within %0d cycles (required within budget)", tag, budget);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({m_axi_arvalid, m_axi_rready, m_cmd_axis_tvalid, m_cmd_axis_tlast, busy, done, error} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 0000000", {m_axi_arvalid, m_axi_rready, m_cmd_axis_tvalid, m_cmd_axis_tlast, busy, done, error});
    end
    total++;
    if (m_axi_araddr !== '0) begin bad++; $display("FAIL reset_araddr: got %h required 0", m_axi_araddr); end
    total++;
    if (m_axi_arlen !== 8'd0) begin bad++; $display("FAIL reset_arlen: got %h required 0", m_axi_arlen); end
    @(negedge aclk);
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    slave_clear();
    kick(25'h000100, 16'd8);
    total++;
    if ({busy, m_axi_arvalid} !== 2'b11) begin bad++; $display("FAIL single_busy_arvalid: got %b required 11", {busy, m_axi_arvalid}); end
    total++;
    if ({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot} !== {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
      bad++;
      $display("FAIL single_ar_fields: got id=%h size=%0d burst=%b lock=%b cache=%b prot=%b required 0 2 01 0 0011 000",
               m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot);
    end
    wait_done(60, "single");
    step(); step();
    total++;
    if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 25'h000100 || ar_len_q[0] !== 8'd7) begin
      bad++;
      $display("FAIL single_ar: got count=%0d addr=%h len=%0d required 1 000100 7", ar_addr_q.size(), ar_addr_q[0], ar_len_q[0]);
    end
    total++;
    if (s_data.size() != 8) begin bad++; $display("FAIL single_beats: got %0d required 8", s_data.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (s_data[i] !== word_at(25'h000100 + 25'(4 * i)) || s_last[i] !== (i == 7)) begin
        bad++;
        $display("FAIL single_beat%0d: got data=%h last=%b required %h %b", i, s_data[i], s_last[i], word_at(25'h000100 + 25'(4 * i)), (i == 7));
      end
    end
    total++;
    if (done_cyc != last_s_cyc + 1 || done_cnt != 1) begin
      bad++;
      $display("FAIL single_done: got cyc=%0d count=%0d required cyc=%0d count=1", done_cyc, done_cnt, last_s_cyc + 1);
    end
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL single_idle: got busy/done=%b required 00", {busy, done}); end
  endtask

  task automatic test_boundary_split();
    logic [AW-1:0] ea [3] = '{25'h000FF0, 25'h001000, 25'h001040};
    logic [7:0]    el [3] = '{8'd3, 8'd15, 8'd0};
    slave_clear();
    kick(25'h000FF0, 16'd21);
    wait_done(200, "split");
    step();
    total++;
    if (ar_addr_q.size() != 3) begin bad++; $display("FAIL split_ar_count: got %0d required 3", ar_addr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ar_addr_q[i] !== ea[i] || ar_len_q[i] !== el[i]) begin
        bad++;
        $display("FAIL split_ar%0d: got addr=%h len=%0d required %h %0d", i, ar_addr_q[i], ar_len_q[i], ea[i], el[i]);
      end
    end
    total++;
    if (s_data.size() != 21) begin bad++; $display("FAIL split_beats: got %0d required 21", s_data.size()); end
    for (int i = 0; i < 21; i++) begin
      total++;
      if (s_data[i] !== word_at(25'h000FF0 + 25'(4 * i)) || s_last[i] !== (i == 20)) begin
        bad++;
        $display("FAIL split_beat%0d: got data=%h last=%b required %h %b", i, s_data[i], s_last[i], word_at(25'h000FF0 + 25'(4 * i)), (i == 20));
      end
    end
  endtask

  task automatic test_zero_length();
    slave_clear();
    kick(25'h000040, 16'd0);
    total++;
    if ({busy, m_axi_arvalid, done} !== 3'b100) begin bad++; $display("FAIL zero_n1: got busy/arvalid/done=%b required 100", {busy, m_axi_arvalid, done}); end
    step();
    total++;
    if ({busy, done} !== 2'b01) begin bad++; $display("FAIL zero_n2: got busy/done=%b required 01", {busy, done}); end
    step();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL zero_n3: got done=%b required 0", done); end
    total++;
    if (ar_addr_q.size() != 0 || busy_cnt != 1 || done_cyc != 2) begin
      bad++;
      $display("FAIL zero_summary: got ars=%0d busy_cycles=%0d done_cyc=%0d required 0 1 2", ar_addr_q.size(), busy_cnt, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] ea [3] = '{25'h002000, 25'h002040, 25'h002080};
    logic [7:0]    el [3] = '{8'd15, 8'd15, 8'd7};
    int nlast = 0;
    slave_clear();
    rand_tready = 1'b1;
    kick(25'h002000, 16'd40);
    for (int n = 0; n < 600 && done_cnt == 0; n++) begin
      if (n == 10) begin start_addr = 25'h000000; length_beats = 16'd3; start = 1'b1; end
      else start = 1'b0;
      step();
    end
    start = 1'b0;
    rand_tready = 1'b0;
    total++;
    if (done_cnt == 0) begin bad++; $display("FAIL bp_timeout: done not seen within 600 cycles (required within budget)"); end
    step();
    total++;
    if (ar_addr_q.size() != 3) begin bad++; $display("FAIL bp_ar_count: got %0d required 3", ar_addr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ar_addr_q[i] !== ea[i] || ar_len_q[i] !== el[i]) begin
        bad++;
        $display("FAIL bp_ar%0d: got addr=%h len=%0d required %h %0d", i, ar_addr_q[i], ar_len_q[i], ea[i], el[i]);
      end
    end
    total++;
    if (s_data.size() != 40) begin bad++; $display("FAIL bp_beats: got %0d required 40", s_data.size()); end
    for (int i = 0; i < 40; i++) begin
      if (s_last[i] === 1'b1) nlast++;
      total++;
      if (s_data[i] !== word_at(25'h002000 + 25'(4 * i))) begin
        bad++;
        $display("FAIL bp_beat%0d: got %h required %h", i, s_data[i], word_at(25'h002000 + 25'(4 * i)));
      end
    end
    total++;
    if (nlast != 1 || s_last[39] !== 1'b1) begin bad++; $display("FAIL bp_tlast: got count=%0d last=%b required 1 1", nlast, s_last[39]); end
  endtask

  task automatic test_slverr();
    slave_clear();
    err_beat = 2;
    kick(25'h000300, 16'd8);
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL err_initial: got %b required 0", error); end
    wait_done(60, "err");
    total++;
    if (s_data.size() != 8) begin bad++; $display("FAIL err_beats: got %0d required 8", s_data.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (s_data[i] !== word_at(25'h000300 + 25'(4 * i))) begin
        bad++;
        $display("FAIL err_beat%0d: got %h required %h", i, s_data[i], word_at(25'h000300 + 25'(4 * i)));
      end
    end
    total++;
    if (err_rise_at != 3) begin bad++; $display("FAIL err_rise: got after %0d R beats required after 3", err_rise_at); end
    for (int i = 0; i < 5; i++) step();
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b required 1", error); end
    err_beat = -1;
    kick(25'h000340, 16'd0);
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL err_clear: got %b required 0", error); end
    step(); step();
  endtask

  task automatic test_reset_midlist();
    slave_clear();
    kick(25'h000400, 16'd16);
    for (int n = 0; n < 100 && s_data.size() < 5; n++) step();
    total++;
    if (s_data.size() != 5 || m_cmd_axis_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: got beats=%0d tvalid=%b required 5 1", s_data.size(), m_cmd_axis_tvalid);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({m_cmd_axis_tvalid, m_axi_arvalid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_async: got tvalid/arvalid/busy=%b required 000", {m_cmd_axis_tvalid, m_axi_arvalid, busy});
    end
    slave_clear();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    @(negedge aclk);
    rst = 1'b0;
    kick(25'h000500, 16'd4);
    wait_done(40, "rstmid");
    total++;
    if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 25'h000500 || ar_len_q[0] !== 8'd3) begin
      bad++;
      $display("FAIL rstmid_ar: got count=%0d addr=%h len=%0d required 1 000500 3", ar_addr_q.size(), ar_addr_q[0], ar_len_q[0]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (s_data[i] !== word_at(25'h000500 + 25'(4 * i)) || s_last[i] !== (i == 3)) begin
        bad++;
        $display("FAIL rstmid_beat%0d: got data=%h last=%b required %h %b", i, s_data[i], s_last[i], word_at(25'h000500 + 25'(4 * i)), (i == 3));
      end
    end
  endtask

  initial begin
    slave_clear();
    test_reset();
    test_single_burst();
    test_boundary_split();
    test_zero_length();
    test_backpressure();
    test_slverr();
    test_reset_midlist();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
